// File: rtl/stream_tol_checker.sv
// Streaming tolerance checker: compares multi-lane beats against a registered-read golden ROM,
// counts failing lanes with saturation, and reports per-beat errors plus run-level done/pass/abort.
module stream_tol_checker #(
   parameter int LANES      = 16,
   parameter int W          = 16,
   parameter int TOL        = 3,
   parameter int FAIL_LIMIT = 48,
   parameter int TOTAL      = 1024,
   parameter int AW         = $clog2(TOTAL / LANES),
   parameter int CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 cmp_signed,
   input  logic [LANES-1:0]     lane_mask,
   input  logic                 in_valid,
   input  logic [LANES*W-1:0]   in_data,
   output logic [AW-1:0]        gold_addr,
   input  logic [LANES*W-1:0]   gold_data,
   output logic                 err_valid,
   output logic [LANES-1:0]     err_lanes,
   output logic [AW-1:0]        err_beat,
   output logic [CNT_W-1:0]     fail_cnt,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic                 abort
);

   localparam int NBEATS = TOTAL / LANES;
   localparam int PW     = $clog2(LANES + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE, ABORT} state_t;

   state_t                state_q, state_d;
   logic [AW-1:0]         beat_cnt;
   logic                  sgn_q;
   logic [LANES-1:0]      mask_q;
   logic                  vld_p0;
   logic [LANES*W-1:0]    dut_p0;
   logic [AW-1:0]         beat_p0;
   logic                  accept, last_beat, res_vld, abort_hit;
   logic [LANES-1:0]      fail_p0;
   logic [PW-1:0]         pop_p0;
   logic [CNT_W-1:0]      cnt_nxt;

   function automatic logic lane_bad(input logic [W-1:0] d, input logic [W-1:0] g,
                                     input logic sgn);
      logic signed [W:0] de, ge, df;
      logic [W:0]        mag;
      de  = sgn ? {d[W-1], d} : {1'b0, d};
      ge  = sgn ? {g[W-1], g} : {1'b0, g};
      df  = de - ge;
      mag = df[W] ? $unsigned(-df) : $unsigned(df);
      return mag > (W+1)'(TOL);
   endfunction

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                input logic [PW-1:0] inc);
      logic [CNT_W:0] s;
      s = {1'b0, cnt} + (CNT_W+1)'(inc);
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   assign accept    = (state_q == RUN) && in_valid && !start;
   assign last_beat = (beat_cnt == AW'(NBEATS - 1));
   assign res_vld   = vld_p0 && !abort && !start;
   assign abort_hit = res_vld && (cnt_nxt >= CNT_W'(FAIL_LIMIT));
   assign gold_addr = beat_cnt;
   assign busy      = (state_q == RUN) || (vld_p0 && !abort);

   // Stage p0 -> result: golden word arrives now, compare lanes and tally failures
   always_comb begin
      fail_p0 = '0;
      pop_p0  = '0;
      for (int k = 0; k < LANES; k++) begin
         fail_p0[k] = mask_q[k] && lane_bad(dut_p0[k*W +: W], gold_data[k*W +: W], sgn_q);
         pop_p0     = pop_p0 + PW'(fail_p0[k]);
      end
      cnt_nxt = sat_add(fail_cnt, pop_p0);
   end

   always_comb begin
      state_d = state_q;
      if (start)
         state_d = RUN;
      else if (abort_hit)
         state_d = ABORT;
      else if (accept && last_beat)
         state_d = DONE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt  <= '0;
         sgn_q     <= 1'b0;
         mask_q    <= '0;
         vld_p0    <= 1'b0;
         err_valid <= 1'b0;
         err_lanes <= '0;
         err_beat  <= '0;
         fail_cnt  <= '0;
         done      <= 1'b0;
         pass      <= 1'b0;
         abort     <= 1'b0;
      end else if (start) begin
         beat_cnt  <= '0;
         sgn_q     <= cmp_signed;
         mask_q    <= lane_mask;
         vld_p0    <= 1'b0;
         err_valid <= 1'b0;
         fail_cnt  <= '0;
         done      <= 1'b0;
         pass      <= 1'b0;
         abort     <= 1'b0;
      end else begin
         vld_p0    <= accept;
         err_valid <= res_vld;
         if (accept)
            beat_cnt <= beat_cnt + 1'b1;
         if (res_vld) begin
            err_lanes <= fail_p0;
            err_beat  <= beat_p0;
            fail_cnt  <= cnt_nxt;
            if (abort_hit) begin
               abort <= 1'b1;
            end else if (beat_p0 == AW'(NBEATS - 1)) begin
               done <= 1'b1;
               pass <= (cnt_nxt == '0);
            end
         end
      end
   end

   // Stage input -> p0: capture the beat alongside its index
   always_ff @(posedge clk) begin
      if (accept) begin
         dut_p0  <= in_data;
         beat_p0 <= beat_cnt;
      end
   end

endmodule
